display_owner_arbiter: RTL and testbench

- Owns the shared 8-digit seven-segment display and decimal point.
- Arbitrates between two sources: the reaction-timer source and the scrolling-message source.
- Replaces the raw mode-switch mux with a debounced mode button, a blanking interval on every ownership change, inactivity auto-switch to the scroller, and preemption back to the timer when a game starts.
- Sits at project top, between both display sources and the board pins.

---
 rtl/disp_arb_pkg.sv | 26 ++
 rtl/button_debounce.sv | 50 +++++
 rtl/display_owner_arbiter.sv | 139 +++++++++++++
 tb/tb_display_owner_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display ownership arbiter and its button front end.
package disp_arb_pkg;

    typedef enum logic [1:0] {
        S_REACT  = 2'd0,
        S_BLANK  = 2'd1,
        S_SCROLL = 2'd2
    } state_e;

    typedef enum logic {
        OWN_REACT  = 1'b0,
        OWN_SCROLL = 1'b1
    } owner_e;

    localparam logic [6:0] BLANK_SEGS = 7'h7F;
    localparam logic [7:0] BLANK_AN   = 8'hFF;

    // Counter width for a count range of 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n > 1) begin
            return $clog2(n);
        end
        return 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces a raw push button; emits a one-cycle pulse on each accepted press.
module button_debounce
    import disp_arb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, rise_q;
    logic [CW-1:0] cnt_q;

    // level_q resets high so a button held through reset must be released before it can fire.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_MAX) begin
                    level_q <= sync2_q;
                    rise_q  <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;

endmodule

// File: rtl/display_owner_arbiter.sv
// Hands the 8-digit display between the reaction timer and the scroller, blanking on every
// ownership change, with debounced manual toggle, idle auto-scroll and game-start preemption.
module display_owner_arbiter
    import disp_arb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLANK_CYCLES    = 100_000,
    parameter int unsigned IDLE_CYCLES     = 1_000_000_000,
    parameter bit          AUTO_SCROLL     = 1'b1
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       react_active,
    input  logic [6:0] react_segs,
    input  logic [7:0] react_an,
    input  logic       react_point,
    input  logic [6:0] scroll_segs,
    input  logic [7:0] scroll_an,
    output logic       scroll_enb,
    output logic       owner,
    output logic [6:0] segs_1,
    output logic [7:0] an,
    output logic       point
);

    localparam int unsigned BW = cnt_width(BLANK_CYCLES);
    localparam int unsigned IW = cnt_width(IDLE_CYCLES);
    localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES - 1);

    logic          mode_level, mode_rise, toggle;
    logic          react_q, react_rise, idle_hit;
    state_e        state_q, state_d;
    owner_e        target_q, target_d;
    logic [BW-1:0] blank_cnt_q;
    logic [IW-1:0] idle_cnt_q;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_btn (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .btn_in    (mode_btn),
        .btn_level (mode_level),
        .btn_rise  (mode_rise)
    );

    assign toggle     = mode_rise & mode_level;
    assign react_rise = react_active & ~react_q;
    assign idle_hit   = AUTO_SCROLL && (idle_cnt_q == IDLE_MAX) && !react_active;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        unique case (state_q)
            S_REACT: begin
                // A toggle during a game is dropped, not deferred.
                if ((toggle && !react_active) || idle_hit) begin
                    state_d  = S_BLANK;
                    target_d = OWN_SCROLL;
                end
            end
            S_SCROLL: begin
                if (toggle || react_rise) begin
                    state_d  = S_BLANK;
                    target_d = OWN_REACT;
                end
            end
            S_BLANK: begin
                if (react_rise) begin
                    target_d = OWN_REACT;
                end
                if (blank_cnt_q == BLANK_MAX) begin
                    state_d = (target_d == OWN_SCROLL) ? S_SCROLL : S_REACT;
                end
            end
            default: state_d = S_REACT;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q     <= S_REACT;
            target_q    <= OWN_REACT;
            react_q     <= 1'b0;
            blank_cnt_q <= '0;
            idle_cnt_q  <= '0;
            owner       <= OWN_REACT;
            scroll_enb  <= 1'b0;
            segs_1      <= BLANK_SEGS;
            an          <= BLANK_AN;
            point       <= 1'b1;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            react_q  <= react_active;

            if (state_q == S_BLANK && state_d == S_BLANK) begin
                blank_cnt_q <= blank_cnt_q + BW'(1);
            end else begin
                blank_cnt_q <= '0;
            end

            if (state_q == S_REACT && state_d == S_REACT && !react_active && !toggle) begin
                if (idle_cnt_q != IDLE_MAX) begin
                    idle_cnt_q <= idle_cnt_q + IW'(1);
                end
            end else begin
                idle_cnt_q <= '0;
            end

            // Pins are driven from the next state so they change on the same edge as ownership.
            unique case (state_d)
                S_REACT: begin
                    segs_1     <= react_segs;
                    an         <= react_an;
                    point      <= react_point;
                    owner      <= OWN_REACT;
                    scroll_enb <= 1'b0;
                end
                S_SCROLL: begin
                    segs_1     <= scroll_segs;
                    an         <= scroll_an;
                    point      <= 1'b1;
                    owner      <= OWN_SCROLL;
                    scroll_enb <= 1'b1;
                end
                default: begin
                    segs_1     <= BLANK_SEGS;
                    an         <= BLANK_AN;
                    point      <= 1'b1;
                    scroll_enb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_owner_arbiter.sv
// Bench for display_owner_arbiter: pass-through tables, directed corner sequences and random
// stimulus, all checked every cycle against a timestamp-based behavioural model.
module tb_display_owner_arbiter;

    localparam int DB = 4;
    localparam int BL = 3;
    localparam int ID = 20;
    localparam int M_REACT  = 0;
    localparam int M_BLANK  = 1;
    localparam int M_SCROLL = 2;

    typedef struct {
        logic [6:0] rs;
        logic [7:0] ra;
        logic       rp;
        logic [6:0] ss;
        logic [7:0] sa;
        logic [6:0] es;
        logic [7:0] ea;
        logic       ep;
    } vec_t;

    logic       clk_100MHz = 1'b0;
    logic       reset, mode_btn, react_active, react_point;
    logic [6:0] react_segs, scroll_segs;
    logic [7:0] react_an, scroll_an;
    logic       scroll_enb, owner, point;
    logic [6:0] segs_1;
    logic [7:0] an;

    display_owner_arbiter #(
        .DEBOUNCE_CYCLES(DB),
        .BLANK_CYCLES   (BL),
        .IDLE_CYCLES    (ID),
        .AUTO_SCROLL    (1'b1)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .mode_btn    (mode_btn),
        .react_active(react_active),
        .react_segs  (react_segs),
        .react_an    (react_an),
        .react_point (react_point),
        .scroll_segs (scroll_segs),
        .scroll_an   (scroll_an),
        .scroll_enb  (scroll_enb),
        .owner       (owner),
        .segs_1      (segs_1),
        .an          (an),
        .point       (point)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int vectors = 0;
    int errors  = 0;

    // Model: edge count n, timestamps for blank entry and last idle-clearing event.
    int  n, m_mode, m_target, m_owner, m_bstart, m_quiet;
    bit  m_s1, m_s2, m_level, m_rise, m_ra_prev;
    bit  hist[$];
    logic [6:0] e_segs;
    logic [7:0] e_an;
    logic       e_point, e_owner, e_enb;

    task automatic model_reset();
        m_mode = M_REACT; m_target = M_REACT; m_owner = 0; m_bstart = 0; m_quiet = n;
        m_s1 = 0; m_s2 = 0; m_level = 1; m_rise = 0; m_ra_prev = 0;
        hist.delete();
        e_segs = 7'h7F; e_an = 8'hFF; e_point = 1'b1; e_owner = 1'b0; e_enb = 1'b0;
    endtask

    task automatic enter_blank(input int tgt);
        m_mode = M_BLANK; m_target = tgt; m_bstart = n;
    endtask

    task automatic model_edge();
        bit tog, accept, ra_rise;
        n++;
        tog = m_rise;
        // A press is accepted once the last DB synchronized samples all disagree with the level.
        hist.push_back(m_s2);
        if (hist.size() > DB) void'(hist.pop_front());
        accept = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] == m_level) accept = 0;
        m_rise = accept && !m_level;
        if (accept) m_level = !m_level;
        m_s2 = m_s1;
        m_s1 = mode_btn;
        ra_rise = react_active && !m_ra_prev;
        m_ra_prev = react_active;
        case (m_mode)
            M_REACT: begin
                if ((tog && !react_active) || (n - m_quiet >= ID && !react_active))
                    enter_blank(M_SCROLL);
                else if (react_active || tog)
                    m_quiet = n;
            end
            M_SCROLL: if (tog || ra_rise) enter_blank(M_REACT);
            default: begin
                if (ra_rise) m_target = M_REACT;
                if (n - m_bstart == BL) begin
                    m_mode  = m_target;
                    m_owner = (m_target == M_SCROLL) ? 1 : 0;
                    m_quiet = n;
                end
            end
        endcase
        case (m_mode)
            M_REACT: begin
                e_segs = react_segs; e_an = react_an; e_point = react_point;
                e_owner = 1'b0; e_enb = 1'b0;
            end
            M_SCROLL: begin
                e_segs = scroll_segs; e_an = scroll_an; e_point = 1'b1;
                e_owner = 1'b1; e_enb = 1'b1;
            end
            default: begin
                e_segs = 7'h7F; e_an = 8'hFF; e_point = 1'b1;
                e_owner = 1'(m_owner); e_enb = 1'b0;
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [6:0] es, input logic [7:0] ea,
                         input logic ep, input logic eo, input logic ee);
        vectors++;
        if ({segs_1, an, point, owner, scroll_enb} !== {es, ea, ep, eo, ee}) begin
            errors++;
            $display("FAIL %s: got segs=%h an=%h point=%b owner=%b enb=%b, want segs=%h an=%h point=%b owner=%b enb=%b",
                     tag, segs_1, an, point, owner, scroll_enb, es, ea, ep, eo, ee);
        end
    endtask

    task automatic expect_val(input string tag, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, act, req);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk_100MHz);
        model_edge();
        #1;
        check(tag, e_segs, e_an, e_point, e_owner, e_enb);
    endtask

    function automatic bit pins_blank();
        return (an == 8'hFF) && (segs_1 == 7'h7F);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tr[6];
        vec_t ts[4];
        int   first_blank, blanks;

        tr[0] = '{7'h40, 8'hFE, 1'b1, 7'h12, 8'hF7, 7'h40, 8'hFE, 1'b1};
        tr[1] = '{7'h00, 8'hFD, 1'b0, 7'h7F, 8'h00, 7'h00, 8'hFD, 1'b0};
        tr[2] = '{7'h7F, 8'h7F, 1'b1, 7'h00, 8'hFF, 7'h7F, 8'h7F, 1'b1};
        tr[3] = '{7'h24, 8'hBF, 1'b0, 7'h3F, 8'hEF, 7'h24, 8'hBF, 1'b0};
        tr[4] = '{7'h79, 8'h00, 1'b1, 7'h55, 8'hAA, 7'h79, 8'h00, 1'b1};
        tr[5] = '{7'h40, 8'hFE, 1'b1, 7'h12, 8'hF7, 7'h40, 8'hFE, 1'b1};
        ts[0] = '{7'h00, 8'h00, 1'b0, 7'h12, 8'hF7, 7'h12, 8'hF7, 1'b1};
        ts[1] = '{7'h7F, 8'hFF, 1'b0, 7'h00, 8'h7F, 7'h00, 8'h7F, 1'b1};
        ts[2] = '{7'h30, 8'hDF, 1'b0, 7'h7F, 8'h00, 7'h7F, 8'h00, 1'b1};
        ts[3] = '{7'h40, 8'hFE, 1'b1, 7'h5B, 8'hFB, 7'h5B, 8'hFB, 1'b1};

        n = 0;
        reset = 1'b1; mode_btn = 1'b0; react_active = 1'b0;
        react_segs = 7'h40; react_an = 8'hFE; react_point = 1'b1;
        scroll_segs = 7'h12; scroll_an = 8'hF7;
        model_reset();
        #2 check("reset_values", 7'h7F, 8'hFF, 1'b1, 1'b0, 1'b0);
        @(posedge clk_100MHz);
        #1 check("reset_held", 7'h7F, 8'hFF, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        #1 check("release_blank", 7'h7F, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick("first_edge");
        check("first_edge_pins", 7'h40, 8'hFE, 1'b1, 1'b0, 1'b0);

        // Timer pass-through, game in progress so idle never fires.
        react_active = 1'b1;
        for (int i = 0; i < 6; i++) begin
            react_segs = tr[i].rs; react_an = tr[i].ra; react_point = tr[i].rp;
            scroll_segs = tr[i].ss; scroll_an = tr[i].sa;
            tick("tbl_react");
            check("tbl_react_exp", tr[i].es, tr[i].ea, tr[i].ep, 1'b0, 1'b0);
        end

        // Press during a game is dropped and not replayed afterwards.
        mode_btn = 1'b1;
        repeat (10) tick("busy_press");
        mode_btn = 1'b0;
        repeat (8) tick("busy_release");
        expect_val("busy_press_owner", int'(owner), 0);
        react_active = 1'b0;
        repeat (5) tick("no_deferred");
        expect_val("no_deferred_owner", int'(owner), 0);
        expect_val("no_deferred_an", int'(an), 'hFE);

        // Bouncing press then a clean hold: one switch to the scroller.
        react_active = 1'b1;
        tick("idle_clear");
        react_active = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mode_btn = ((k % 4) < 2);
            tick("bounce");
        end
        mode_btn = 1'b1;
        blanks = 0;
        repeat (12) begin
            tick("hold");
            if (pins_blank()) blanks++;
        end
        expect_val("bounce_blank_cycles", blanks, 3);
        expect_val("bounce_owner", int'(owner), 1);
        expect_val("bounce_enb", int'(scroll_enb), 1);
        expect_val("bounce_segs", int'(segs_1), 'h12);

        mode_btn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            react_segs = ts[i].rs; react_an = ts[i].ra; react_point = ts[i].rp;
            scroll_segs = ts[i].ss; scroll_an = ts[i].sa;
            tick("tbl_scroll");
            check("tbl_scroll_exp", ts[i].es, ts[i].ea, ts[i].ep, 1'b1, 1'b1);
        end

        // Game start preempts the scroller.
        react_active = 1'b1;
        tick("preempt");
        check("preempt_blank", 7'h7F, 8'hFF, 1'b1, 1'b1, 1'b0);
        tick("preempt");
        tick("preempt");
        expect_val("preempt_hold_owner", int'(owner), 1);
        tick("preempt");
        check("preempt_exit", 7'h40, 8'hFE, 1'b1, 1'b0, 1'b0);

        // Inactivity auto-switch.
        react_active = 1'b0;
        first_blank = -1;
        for (int i = 1; i <= 30; i++) begin
            tick("idle");
            if (pins_blank()) begin
                first_blank = i;
                break;
            end
        end
        expect_val("idle_first_blank", first_blank, 20);
        repeat (3) tick("idle_blank");
        expect_val("idle_owner", int'(owner), 1);
        expect_val("idle_enb", int'(scroll_enb), 1);

        react_active = 1'b1;
        repeat (5) tick("preempt2");
        expect_val("preempt2_owner", int'(owner), 0);

        // A game pulse restarts the idle window; then a game start mid-blank redirects the exit.
        react_active = 1'b0;
        repeat (15) tick("idle_pre");
        react_active = 1'b1;
        tick("idle_pulse");
        react_active = 1'b0;
        first_blank = -1;
        for (int i = 1; i <= 30; i++) begin
            tick("idle2");
            if (pins_blank()) begin
                first_blank = i;
                break;
            end
        end
        expect_val("idle_restart_first_blank", first_blank, 20);
        react_active = 1'b1;
        tick("late_rise");
        check("late_rise_blank", 7'h7F, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick("late_rise");
        tick("late_rise");
        check("late_rise_exit", 7'h40, 8'hFE, 1'b1, 1'b0, 1'b0);

        // Reset during blanking with the button held.
        react_active = 1'b0;
        mode_btn = 1'b1;
        first_blank = -1;
        for (int i = 1; i <= 12; i++) begin
            tick("press_to_blank");
            if (pins_blank()) begin
                first_blank = i;
                break;
            end
        end
        expect_val("press_first_blank", first_blank, 7);
        reset = 1'b1;
        #1 check("reset_mid", 7'h7F, 8'hFF, 1'b1, 1'b0, 1'b0);
        model_reset();
        @(posedge clk_100MHz);
        #1 check("reset_mid_held", 7'h7F, 8'hFF, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        blanks = 0;
        repeat (12) begin
            tick("held_through_reset");
            if (pins_blank()) blanks++;
        end
        expect_val("held_through_reset_blanks", blanks, 0);
        expect_val("held_through_reset_owner", int'(owner), 0);
        mode_btn = 1'b0;
        react_active = 1'b1;
        tick("release");
        react_active = 1'b0;
        repeat (7) tick("release");
        mode_btn = 1'b1;
        first_blank = -1;
        for (int i = 1; i <= 12; i++) begin
            tick("repress");
            if (pins_blank()) begin
                first_blank = i;
                break;
            end
        end
        expect_val("repress_first_blank", first_blank, 7);
        repeat (6) tick("settle");

        // Random traffic against the model.
        repeat (400) begin
            react_segs  = 7'($urandom);
            react_an    = 8'($urandom);
            react_point = 1'($urandom);
            scroll_segs = 7'($urandom);
            scroll_an   = 8'($urandom);
            if ($urandom_range(0, 15) == 0) react_active = ~react_active;
            if ($urandom_range(0, 5) == 0) mode_btn = ~mode_btn;
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
